pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Consumes the PLL lock indication and produces staged, synchronous reset releases for the memory, core and peripheral domains. It runs on the PLL output clock. It holds every domain in reset until lock has been continuously stable for a programmable window, then releases domains in order. Any lock loss re-asserts all domain resets immediately, and a software-requested soft reset re-sequences core and peripherals only.

## Interface
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before the first release; must be ≥1.
- STAGE_GAP_CYCLES, 16: cycles between successive stage releases and the length of a soft reset; must be ≥1.
- SYNC_STAGES, 2: flip-flop depth of the pll_lock synchronizer; must be ≥2.
- CNT_W, 16: counter width; must hold max(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES)-1.
- clk  in  1  PLL output clock; the only clock.
- reset  in  1  synchronous, active-high.
- pll_lock  in  1  raw PLL LOCK, asynchronous to clk.
- soft_reset_req  in  1  single-cycle request, synchronous to clk.
- rst_mem  out  1  memory-domain reset, active-high.
- rst_core  out  1  processor-core reset, active-high.
- rst_periph  out  1  peripheral reset, active-high.
- ready  out  1  high only in RUN.
- lock_lost_count  out  8  count of lock losses after the first release began; saturates at 255.
- state  out  3  current FSM encoding, for debug.

## Operation
- Synchronizer: SYNC_STAGES flops, all reset to 0. lock_s is the last flop. The FSM uses only lock_s.
- States and encodings: WAIT_LOCK=0, STABLE=1, REL_MEM=2, REL_CORE=3, RUN=4, SOFT=5. Codes 6 and 7 go to WAIT_LOCK on the next edge.
- One shared counter cnt is cleared on every state change.
- WAIT_LOCK: if lock_s=1, go to STABLE.
- STABLE: cnt increments while lock_s=1.
  - When cnt=LOCK_STABLE_CYCLES-1 and lock_s=1, go to REL_MEM.
  - If lock_s=0, go to WAIT_LOCK. No count increment.
- REL_MEM: when cnt=STAGE_GAP_CYCLES-1, go to REL_CORE.
- REL_CORE: when cnt=STAGE_GAP_CYCLES-1, go to RUN.
- RUN: stays in RUN. If soft_reset_req=1, go to SOFT.
- SOFT: when cnt=STAGE_GAP_CYCLES-1, go to REL_CORE.
- Lock loss: lock_s=0 in REL_MEM, REL_CORE, RUN or SOFT sends the FSM to WAIT_LOCK and increments lock_lost_count (saturating).
- Priority: reset > lock loss > soft_reset_req > counter expiry.
- soft_reset_req is ignored outside RUN.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - rst_mem=0 in REL_MEM, REL_CORE, RUN, SOFT; otherwise 1.
  - rst_core=0 in REL_CORE, RUN; otherwise 1.
  - rst_periph=0 in RUN only; otherwise 1.
  - ready = (state==RUN).
- Releases always happen in order: rst_mem, then rst_core, then rst_periph. Assertion on lock loss is simultaneous for all three.

## Timing
- While reset=1 and on the edge where reset is sampled high:
  - state=WAIT_LOCK, cnt=0, synchronizer=0.
  - rst_mem=rst_core=rst_periph=1, ready=0, lock_lost_count=0.
- Reset asserted mid-sequence aborts the sequence on that edge. lock_lost_count is cleared.
- Edge 0 is the first edge at which pll_lock is sampled 1 with reset=0, and lock stays high.
  - lock_s=1 after edge SYNC_STAGES-1.
  - STABLE is entered at edge SYNC_STAGES.
  - rst_mem falls at edge T = SYNC_STAGES + LOCK_STABLE_CYCLES.
  - rst_core falls at T + STAGE_GAP_CYCLES.
  - rst_periph falls and ready rises at T + 2·STAGE_GAP_CYCLES.
- Lock loss latency: pll_lock falling and sampled at edge m gives all resets high and ready=0 at edge m+SYNC_STAGES. The counter increments on the same edge.
- Soft reset: soft_reset_req sampled at edge s in RUN.
  - rst_core, rst_periph =1 and ready=0 at edge s.
  - rst_mem stays 0.
  - rst_core falls at s+STAGE_GAP_CYCLES.
  - rst_periph falls and ready rises at s+2·STAGE_GAP_CYCLES.
- Lock dropout in STABLE restarts the full LOCK_STABLE_CYCLES window after relock. lock_lost_count is unchanged.

## Test plan
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4.
- Clean power-up: reset for 3 cycles, then pll_lock=1 from edge 0.
  - Expect rst_mem falling at edge 10, rst_core at 14, rst_periph and ready at 18.
  - Expect state to step 0→1→2→3→4; lock_lost_count=0.
- Lock glitch in STABLE: pll_lock low for one cycle at edge 5.
  - Expect return to WAIT_LOCK and all resets still 1.
  - Expect the full 8-cycle window restarting after relock; lock_lost_count=0.
- Lock loss in RUN: drop pll_lock at edge 30.
  - Expect rst_mem, rst_core, rst_periph=1 and ready=0 at edge 32; lock_lost_count=1.
  - On relock, expect the full staged sequence to repeat.
- Soft reset: pulse soft_reset_req at edge 25 in RUN.
  - Expect rst_core and rst_periph=1 at edge 25 with rst_mem=0 throughout.
  - Expect rst_core=0 at 29 and rst_periph=0, ready=1 at 33.
  - A second pulse at edge 27 (during SOFT) has no effect.
- Simultaneous events: soft_reset_req=1 on the same edge lock_s falls in RUN.
  - Expect WAIT_LOCK with all resets=1 and lock_lost_count incremented.
  - Separately, 300 lock losses in RUN must leave lock_lost_count=255.
- Mid-sequence reset: assert reset in REL_CORE.
  - Expect all resets=1, ready=0, lock_lost_count=0 and state=0 on that edge.
  - Expect the sequence to restart only after reset=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Staged reset release for memory, core and peripheral domains, gated on a
// synchronized PLL lock that must stay stable for a programmable window.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int CNT_W              = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       soft_reset_req,
  output logic       rst_mem,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       ready,
  output logic [7:0] lock_lost_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    REL_MEM   = 3'd2,
    REL_CORE  = 3'd3,
    RUN       = 3'd4,
    SOFT      = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] lost_q, lost_d;
  logic       rst_mem_q, rst_mem_d;
  logic       rst_core_q, rst_core_d;
  logic       rst_periph_q, rst_periph_d;
  logic       ready_q, ready_d;
  logic       lock_lost;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Lock loss outranks a soft reset request, which outranks counter expiry.
  always_comb begin
    state_d   = state_q;
    lock_lost = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = REL_MEM;
      end
      REL_MEM: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          lock_lost = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = REL_CORE;
        end
      end
      REL_CORE: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          lock_lost = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          lock_lost = 1'b1;
        end else if (soft_reset_req) begin
          state_d = SOFT;
        end
      end
      SOFT: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          lock_lost = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = REL_CORE;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == STABLE || state_q == REL_MEM ||
         state_q == REL_CORE || state_q == SOFT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    lost_d = lost_q;
    if (lock_lost && lost_q != 8'hFF) lost_d = lost_q + 8'd1;
  end

  // Outputs are decoded from the next state so they move with the state edge.
  always_comb begin
    rst_mem_d    = !(state_d == REL_MEM || state_d == REL_CORE ||
                     state_d == RUN || state_d == SOFT);
    rst_core_d   = !(state_d == REL_CORE || state_d == RUN);
    rst_periph_d = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      lost_q       <= '0;
      rst_mem_q    <= 1'b1;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lost_q       <= lost_d;
      rst_mem_q    <= rst_mem_d;
      rst_core_q   <= rst_core_d;
      rst_periph_q <= rst_periph_d;
      ready_q      <= ready_d;
    end
  end

  assign rst_mem         = rst_mem_q;
  assign rst_core        = rst_core_q;
  assign rst_periph      = rst_periph_q;
  assign ready           = ready_q;
  assign lock_lost_count = lost_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with SYNC=2, LOCK window 8, stage gap 4.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LSC  = 8;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       soft_reset_req;
  logic       rst_mem, rst_core, rst_periph, ready;
  logic [7:0] lock_lost_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP_CYCLES(GAP),
    .SYNC_STAGES(SYNC),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_lock(pll_lock),
    .soft_reset_req(soft_reset_req),
    .rst_mem(rst_mem),
    .rst_core(rst_core),
    .rst_periph(rst_periph),
    .ready(ready),
    .lock_lost_count(lock_lost_count),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetOutputs(input string tag, input int unsigned lost);
    checkOutput({tag, ".state"}, state, 0);
    checkOutput({tag, ".rst_mem"}, rst_mem, 1);
    checkOutput({tag, ".rst_core"}, rst_core, 1);
    checkOutput({tag, ".rst_periph"}, rst_periph, 1);
    checkOutput({tag, ".ready"}, ready, 0);
    checkOutput({tag, ".lost"}, lock_lost_count, lost);
  endtask

  // Caller has just set pll_lock=1 with reset low; the next edge is edge 0.
  task automatic checkSequence(input string tag);
    int t;
    int unsigned expState;
    t = SYNC + LSC;
    for (int e = 0; e <= t + 2 * GAP; e++) begin
      tick(1);
      if (e < SYNC) expState = 0;
      else if (e < t) expState = 1;
      else if (e < t + GAP) expState = 2;
      else if (e < t + 2 * GAP) expState = 3;
      else expState = 4;
      checkOutput($sformatf("%s.e%0d.state", tag, e), state, expState);
      checkOutput($sformatf("%s.e%0d.rst_mem", tag, e), rst_mem, (e < t) ? 1 : 0);
      checkOutput($sformatf("%s.e%0d.rst_core", tag, e), rst_core, (e < t + GAP) ? 1 : 0);
      checkOutput($sformatf("%s.e%0d.rst_periph", tag, e), rst_periph, (e < t + 2 * GAP) ? 1 : 0);
      checkOutput($sformatf("%s.e%0d.ready", tag, e), ready, (e >= t + 2 * GAP) ? 1 : 0);
    end
  endtask

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick(1);
      n++;
    end
    if (!ready) checkOutput({tag, ".readyTimeout"}, ready, 1);
  endtask

  task automatic applyStimulus();
    // Clean power-up
    reset = 1'b1;
    pll_lock = 1'b0;
    soft_reset_req = 1'b0;
    tick(3);
    checkResetOutputs("reset", 0);
    reset = 1'b0;
    pll_lock = 1'b1;
    checkSequence("powerup");
    checkOutput("powerup.lost", lock_lost_count, 0);

    // Lock glitch in STABLE: pll_lock sampled low at edge 5 only
    reset = 1'b1;
    pll_lock = 1'b0;
    tick(2);
    reset = 1'b0;
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    checkOutput("glitch.e6.state", state, 1);
    tick(1);
    checkOutput("glitch.e7.state", state, 0);
    checkOutput("glitch.e7.rst_mem", rst_mem, 1);
    tick(1);
    checkOutput("glitch.e8.state", state, 1);
    tick(7);
    checkOutput("glitch.e15.state", state, 1);
    checkOutput("glitch.e15.rst_mem", rst_mem, 1);
    tick(1);
    checkOutput("glitch.e16.state", state, 2);
    checkOutput("glitch.e16.rst_mem", rst_mem, 0);
    checkOutput("glitch.e16.rst_core", rst_core, 1);
    tick(8);
    checkOutput("glitch.e24.ready", ready, 1);
    checkOutput("glitch.lost", lock_lost_count, 0);

    // Lock loss in RUN: pll_lock sampled low at edge m
    pll_lock = 1'b0;
    tick(1);
    checkOutput("loss.m.ready", ready, 1);
    tick(1);
    checkOutput("loss.m1.state", state, 4);
    checkOutput("loss.m1.ready", ready, 1);
    tick(1);
    checkResetOutputs("loss.m2", 1);
    pll_lock = 1'b1;
    checkSequence("relock");
    checkOutput("relock.lost", lock_lost_count, 1);

    // Soft reset sampled at edge s, second request at s+2 ignored
    tick(1);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    checkOutput("soft.s.state", state, 5);
    checkOutput("soft.s.rst_core", rst_core, 1);
    checkOutput("soft.s.rst_periph", rst_periph, 1);
    checkOutput("soft.s.ready", ready, 0);
    checkOutput("soft.s.rst_mem", rst_mem, 0);
    tick(1);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    checkOutput("soft.s2.state", state, 5);
    tick(1);
    checkOutput("soft.s3.rst_core", rst_core, 1);
    tick(1);
    checkOutput("soft.s4.state", state, 3);
    checkOutput("soft.s4.rst_core", rst_core, 0);
    checkOutput("soft.s4.rst_periph", rst_periph, 1);
    checkOutput("soft.s4.rst_mem", rst_mem, 0);
    tick(3);
    checkOutput("soft.s7.rst_periph", rst_periph, 1);
    checkOutput("soft.s7.ready", ready, 0);
    tick(1);
    checkOutput("soft.s8.state", state, 4);
    checkOutput("soft.s8.rst_periph", rst_periph, 0);
    checkOutput("soft.s8.ready", ready, 1);
    checkOutput("soft.s8.rst_mem", rst_mem, 0);
    checkOutput("soft.lost", lock_lost_count, 1);

    // Soft request on the edge where lock_s falls: lock loss wins
    pll_lock = 1'b0;
    tick(2);
    checkOutput("simul.m1.state", state, 4);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    checkResetOutputs("simul.m2", 2);
    tick(1);
    checkOutput("simul.m3.state", state, 0);
    pll_lock = 1'b1;
    checkSequence("afterSimul");

    // Saturation of lock_lost_count
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      tick(3);
      if (i == 251) checkOutput("sat.254", lock_lost_count, 254);
      if (i == 252) checkOutput("sat.255", lock_lost_count, 255);
      pll_lock = 1'b1;
      waitReady($sformatf("sat.i%0d", i));
    end
    checkOutput("sat.final", lock_lost_count, 255);

    // Reset asserted while in REL_CORE
    pll_lock = 1'b0;
    tick(3);
    checkOutput("midrst.pre.lost", lock_lost_count, 255);
    pll_lock = 1'b1;
    tick(16);
    checkOutput("midrst.e15.state", state, 3);
    reset = 1'b1;
    tick(1);
    checkResetOutputs("midrst.e16", 0);
    tick(2);
    checkOutput("midrst.held.state", state, 0);
    checkOutput("midrst.held.rst_mem", rst_mem, 1);
    reset = 1'b0;
    checkSequence("postReset");
    checkOutput("postReset.lost", lock_lost_count, 0);
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d, errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
